// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency loads with store forwarding from an
// in-order write buffer that drains into a single-port word array.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WB_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 proc2Dmem_command,
    input  logic [31:0]                proc2Dmem_addr,
    input  logic [31:0]                proc2Dmem_data,
    output logic [31:0]                mem2proc_data,
    output logic                       mem_busy,
    output logic                       mem_err,
    output logic [$clog2(WB_DEPTH):0]  wb_count,
    output logic                       wb_empty
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [31:0]   mem_q     [DEPTH_WORDS];
    logic [AW-1:0] wb_addr_q [WB_DEPTH];
    logic [31:0]   wb_data_q [WB_DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          is_load, is_store, in_range, bad_access;
    logic          accept, drain, full;
    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    assign is_load    = (proc2Dmem_command == BUS_LOAD);
    assign is_store   = (proc2Dmem_command == BUS_STORE);
    assign word_idx   = proc2Dmem_addr[31:2];
    assign mem_idx    = word_idx[AW-1:0];
    assign in_range   = (proc2Dmem_addr[1:0] == 2'b00) && ({2'b00, word_idx} < 32'(DEPTH_WORDS));
    assign bad_access = (is_load || is_store) && !in_range;

    assign full   = (count_q == CW'(WB_DEPTH));
    assign accept = is_store && in_range && !full;
    // Array is single-port: any non-load cycle is free for one drain write.
    assign drain  = !is_load && (count_q != '0);

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if ((CW'(k) < count_q) && (wb_addr_q[PW'(head_q + PW'(k))] == mem_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[PW'(head_q + PW'(k))];
            end
        end
    end

    always_comb begin
        mem2proc_data = '0;
        if (is_load && in_range) begin
            mem2proc_data = fwd_hit ? fwd_data : mem_q[mem_idx];
        end
    end

    always_comb begin
        head_d  = drain  ? head_q + 1'b1 : head_q;
        tail_d  = accept ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(accept) - CW'(drain);
        err_d   = err_q | bad_access;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; an empty count makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (accept) begin
            wb_addr_q[tail_q] <= mem_idx;
            wb_data_q[tail_q] <= proc2Dmem_data;
        end
        if (drain) begin
            mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
        end
    end

    assign mem_busy = full;
    assign mem_err  = err_q;
    assign wb_count = count_q;
    assign wb_empty = (count_q == '0);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset
// sequences and random traffic checked against a queue-based reference.
module tb_dmem_responder;

    localparam int DW  = 1024;
    localparam int WBD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cmd;
    logic [31:0] addr, wdata;
    logic [31:0] mem2proc_data;
    logic        mem_busy, mem_err, wb_empty;
    logic [2:0]  wb_count;

    dmem_responder #(.DEPTH_WORDS(DW), .WB_DEPTH(WBD)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .proc2Dmem_command (cmd),
        .proc2Dmem_addr    (addr),
        .proc2Dmem_data    (wdata),
        .mem2proc_data     (mem2proc_data),
        .mem_busy          (mem_busy),
        .mem_err           (mem_err),
        .wb_count          (wb_count),
        .wb_empty          (wb_empty)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Reference: pending stores in program order, plus the array image.
    typedef struct {
        int          idx;
        logic [31:0] data;
    } ent_t;
    ent_t        pend[$];
    logic [31:0] arr[DW];
    bit          known[DW];
    bit          err_m = 1'b0;

    typedef struct {
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          cnt;
        logic        busy;
        logic        err;
    } vec_t;
    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit good(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DW));
    endfunction

    task automatic model_check(input string tag);
        logic [31:0] exp_rd;
        bit          rd_valid;
        exp_rd   = '0;
        rd_valid = 1'b1;
        if (cmd == 2'd1 && good(addr)) begin
            int  idx;
            bit  hit;
            idx = int'(addr[31:2]);
            hit = 1'b0;
            for (int i = pend.size() - 1; i >= 0 && !hit; i--) begin
                if (pend[i].idx == idx) begin
                    exp_rd = pend[i].data;
                    hit    = 1'b1;
                end
            end
            if (!hit) begin
                rd_valid = known[idx];
                exp_rd   = arr[idx];
            end
        end
        if (rd_valid) chk({tag, "_rd"}, mem2proc_data, exp_rd);
        chk({tag, "_cnt"},   32'(wb_count), 32'(pend.size()));
        chk({tag, "_busy"},  32'(mem_busy), 32'(pend.size() == WBD));
        chk({tag, "_empty"}, 32'(wb_empty), 32'(pend.size() == 0));
        chk({tag, "_err"},   32'(mem_err),  32'(err_m));
    endtask

    task automatic model_edge();
        bit   ld, acc, dr;
        ent_t e;
        ld  = (cmd == 2'd1);
        acc = (cmd == 2'd2) && good(addr) && (pend.size() < WBD);
        dr  = !ld && (pend.size() > 0);
        if ((cmd == 2'd1 || cmd == 2'd2) && !good(addr)) err_m = 1'b1;
        if (dr) begin
            e = pend.pop_front();
            arr[e.idx]   = e.data;
            known[e.idx] = 1'b1;
        end
        if (acc) begin
            e.idx  = int'(addr[31:2]);
            e.data = wdata;
            pend.push_back(e);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d, input string tag);
        cmd = c; addr = a; wdata = d;
        @(negedge clk);
        model_check(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd = 2'd0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        pend.delete();
        err_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tv[0]  = '{2'd2, 32'h20,   32'h1111_2222, 32'h0,          0, 1'b0, 1'b0};
        tv[1]  = '{2'd1, 32'h20,   32'h0,         32'h1111_2222, 1, 1'b0, 1'b0};
        tv[2]  = '{2'd0, 32'h20,   32'h0,         32'h0,          1, 1'b0, 1'b0};
        tv[3]  = '{2'd1, 32'h20,   32'h0,         32'h1111_2222, 0, 1'b0, 1'b0};
        tv[4]  = '{2'd2, 32'h40,   32'hAAAA_0001, 32'h0,          0, 1'b0, 1'b0};
        tv[5]  = '{2'd1, 32'h40,   32'h0,         32'hAAAA_0001, 1, 1'b0, 1'b0};
        tv[6]  = '{2'd2, 32'h40,   32'hBBBB_0002, 32'h0,          1, 1'b0, 1'b0};
        tv[7]  = '{2'd1, 32'h40,   32'h0,         32'hBBBB_0002, 1, 1'b0, 1'b0};
        tv[8]  = '{2'd0, 32'h40,   32'h0,         32'h0,          1, 1'b0, 1'b0};
        tv[9]  = '{2'd1, 32'h40,   32'h0,         32'hBBBB_0002, 0, 1'b0, 1'b0};
        tv[10] = '{2'd1, 32'h2,    32'h0,         32'h0,          0, 1'b0, 1'b0};
        tv[11] = '{2'd0, 32'h0,    32'h0,         32'h0,          0, 1'b0, 1'b1};
        tv[12] = '{2'd2, 32'h1000, 32'h5,         32'h0,          0, 1'b0, 1'b1};
        tv[13] = '{2'd0, 32'h0,    32'h0,         32'h0,          0, 1'b0, 1'b1};
        tv[14] = '{2'd1, 32'h1000, 32'h0,         32'h0,          0, 1'b0, 1'b1};

        rst_n = 1'b0; cmd = 2'd0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt",   32'(wb_count), 32'd0);
        chk("rst_empty", 32'(wb_empty), 32'd1);
        chk("rst_busy",  32'(mem_busy), 32'd0);
        chk("rst_err",   32'(mem_err),  32'd0);
        rst_n = 1'b1;

        // Fill words 0..31 through the bus so every later load is predictable.
        for (int i = 0; i < 32; i++) step(2'd2, 32'(i * 4), $urandom, "pre");
        step(2'd0, 32'h0, 32'h0, "pre_drain");
        step(2'd2, 32'h10, 32'hDEAD_BEEF, "pre_beef");
        step(2'd0, 32'h0, 32'h0, "pre_drain2");

        // Array contents must survive reset.
        do_reset();
        cmd = 2'd1; addr = 32'h10; wdata = '0;
        @(negedge clk);
        chk("t1_rd",    mem2proc_data, 32'hDEAD_BEEF);
        chk("t1_empty", 32'(wb_empty), 32'd1);
        chk("t1_err",   32'(mem_err),  32'd0);
        model_edge();
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            cmd = tv[i].c; addr = tv[i].a; wdata = tv[i].d;
            @(negedge clk);
            chk($sformatf("tv%0d_rd", i),   mem2proc_data,  tv[i].rd);
            chk($sformatf("tv%0d_cnt", i),  32'(wb_count),  32'(tv[i].cnt));
            chk($sformatf("tv%0d_busy", i), 32'(mem_busy),  32'(tv[i].busy));
            chk($sformatf("tv%0d_err", i),  32'(mem_err),   32'(tv[i].err));
            model_edge();
            @(posedge clk);
            #1;
        end

        // Back-to-back stores with loads between, then a free cycle.
        do_reset();
        for (int i = 0; i <= WBD; i++) begin
            step(2'd2, 32'h60, 32'(32'hC000_0000 + i), "burst_st");
            step(2'd1, 32'h60, 32'h0, "burst_ld");
        end
        step(2'd0, 32'h0, 32'h0, "burst_none");
        step(2'd1, 32'h60, 32'h0, "burst_final");

        // Reset arriving mid-cycle with a store still pending.
        do_reset();
        step(2'd2, 32'h30, 32'h0000_0077, "t6_st");
        cmd = 2'd1; addr = 32'h30; wdata = '0;
        @(negedge clk);
        chk("t6_fwd", mem2proc_data, 32'h0000_0077);
        chk("t6_cnt", 32'(wb_count), 32'd1);
        #1;
        rst_n = 1'b0;
        pend.delete();
        err_m = 1'b0;
        #1;
        chk("t6_rst_cnt",   32'(wb_count), 32'd0);
        chk("t6_rst_empty", 32'(wb_empty), 32'd1);
        cmd = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'd1, 32'h30, 32'h0, "t6_old");

        // Random traffic, including idle command 3 and bad addresses.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            int          r;
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            else             a = 32'($urandom_range(0, 31)) << 2;
            step(2'($urandom_range(0, 3)), a, $urandom, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
